// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_SRC registered-read FIFOs into one valid/ready stream.
// Reads are only issued when the 2-entry output buffer can absorb them, so back-pressure never drops a word.
module fifo_drain_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATAWIDTH = 32,
  parameter int BURST_MAX = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_SRC-1:0]             src_empty,
  output logic [NUM_SRC-1:0]             src_read_en,
  input  logic [NUM_SRC*DATAWIDTH-1:0]   src_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATAWIDTH-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0]     out_src,
  output logic                           busy,
  output logic                           dbg_state
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state, state_n;
  logic [SW-1:0]          grant, grant_n;
  logic [SW-1:0]          last_grant, last_grant_n;
  logic [BW-1:0]          burst, burst_n;
  logic                   inflight;
  logic [SW-1:0]          inflight_src;
  logic [DATAWIDTH-1:0]   mem_data [2];
  logic [SW-1:0]          mem_src  [2];
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             occ;

  logic                   pop, space_ok, found, rd;
  logic [SW-1:0]          pick, rd_src;
  logic [DATAWIDTH-1:0]   cap_data;

  // Handshake: a word moves downstream in any cycle where out_valid && out_ready.
  assign pop       = out_valid && out_ready;
  assign space_ok  = (({1'b0, occ} + {2'b0, inflight}) - {2'b0, pop}) < 3'd2;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_src   = mem_src[rd_ptr];
  assign busy      = (state == GRANT) || inflight || (occ != 2'd0);
  assign dbg_state = state;
  assign cap_data  = src_data[inflight_src*DATAWIDTH +: DATAWIDTH];

  // First non-empty source searching upward from last_grant+1, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!found && !src_empty[(int'(last_grant) + i) % NUM_SRC]) begin
        found = 1'b1;
        pick  = SW'((int'(last_grant) + i) % NUM_SRC);
      end
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    burst_n      = burst;
    rd           = 1'b0;
    rd_src       = grant;
    case (state)
      IDLE: begin
        if (enable && found) begin
          state_n = GRANT;
          grant_n = pick;
          rd_src  = pick;
          rd      = space_ok;
        end
      end
      GRANT: begin
        if (!enable || src_empty[grant] || (burst == BW'(BURST_MAX))) begin
          state_n      = IDLE;
          last_grant_n = grant;
          burst_n      = '0;
        end else begin
          rd = space_ok;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) rd = 1'b0;
    if (rd) burst_n = burst + BW'(1);
  end

  always_comb begin
    src_read_en = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_read_en[i] = rd && (rd_src == SW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= SW'(NUM_SRC - 1);
      burst        <= '0;
      inflight     <= 1'b0;
      inflight_src <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      occ          <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_src[i]  <= '0;
      end
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      burst      <= burst_n;
      inflight   <= rd;
      if (rd) inflight_src <= rd_src;
      // Source index comes from the issue cycle, not the current grant.
      if (inflight) begin
        mem_data[wr_ptr] <= cap_data;
        mem_src[wr_ptr]  <= inflight_src;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= (occ + {1'b0, inflight}) - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: cycle table for a short burst plus
// multi-cycle sequences with a read-order and output-word scoreboard.
module tb_fifo_drain_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int W  = DW + SW;

  logic              clk = 1'b0;
  logic              rst, enable, out_ready;
  logic [NS-1:0]     src_empty, src_read_en;
  logic [NS*DW-1:0]  src_data;
  logic              out_valid, busy, dbg_state;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_src;

  fifo_drain_arbiter #(.NUM_SRC(NS), .DATAWIDTH(DW), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .src_empty(src_empty),
    .src_read_en(src_read_en), .src_data(src_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int s, input int k);
    return {4'hA, 4'(s), 24'(k)};
  endfunction

  // Source FIFO models: registered read data, empty updates the cycle after read_en.
  int            rd_idx [NS] = '{default: 0};
  int            lim    [NS];
  logic [DW-1:0] data_arr [NS] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (src_read_en[i]) begin
        data_arr[i] <= word(i, rd_idx[i]);
        rd_idx[i]   <= rd_idx[i] + 1;
      end
    end
  end

  always_comb begin
    src_empty = '0;
    src_data  = '0;
    for (int i = 0; i < NS; i++) begin
      src_empty[i]         = (rd_idx[i] >= lim[i]);
      src_data[i*DW +: DW] = data_arr[i];
    end
  end

  int n_tests, n_fail;
  int next_idx [NS];
  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] exp_rd_q[$];
  int outstanding, gaps, delivered, strobes;
  bit started, mon_on;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NS-1:0] v);
    int r = 0;
    for (int i = 0; i < NS; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic monitor();
    logic p;
    logic [SW-1:0] e;
    logic [W-1:0]  ew;
    p = out_valid && out_ready;
    if (src_read_en != '0) begin
      strobes++;
      started = 1'b1;
      check("one_hot", 64'($countones(src_read_en)), 64'd1);
      check("space_rule", 64'((outstanding - int'(p)) < 2), 64'd1);
      if (exp_rd_q.size() == 0) begin
        check("unexpected_read", 64'(oh_idx(src_read_en)), 64'hFF);
      end else begin
        e = exp_rd_q.pop_front();
        check("read_src", 64'(oh_idx(src_read_en)), 64'(e));
      end
    end else if (started && exp_rd_q.size() != 0) begin
      gaps++;
    end
    if (p) begin
      delivered++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", {out_src, out_data}, 64'hDEAD);
      end else begin
        ew = exp_q.pop_front();
        check("out_word", {out_src, out_data}, 64'(ew));
      end
    end
    outstanding = outstanding + int'(src_read_en != '0) - int'(p);
  endtask

  task automatic step(input logic en, input logic rdy);
    @(negedge clk);
    enable    = en;
    out_ready = rdy;
    #2;
    if (mon_on) monitor();
  endtask

  task automatic clear_mon();
    exp_q.delete();
    exp_rd_q.delete();
    outstanding = 0; gaps = 0; delivered = 0; strobes = 0; started = 1'b0;
  endtask

  task automatic start_scenario();
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
    clear_mon();
    mon_on = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic check_zero(input string name);
    #1;
    check(name, {src_read_en, out_valid, out_data, out_src, busy}, 64'd0);
  endtask

  task automatic load(input int s, input int n);
    lim[s] = lim[s] + n;
  endtask

  task automatic expect_burst(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      exp_rd_q.push_back(SW'(s));
      exp_q.push_back({SW'(s), word(s, next_idx[s])});
      next_idx[s]++;
    end
  endtask

  task automatic run_until_empty(input string name, input int budget);
    for (int c = 0; c < budget && (exp_q.size() != 0 || exp_rd_q.size() != 0); c++) step(1'b1, 1'b1);
    check({name, "_drained"}, 64'(exp_q.size() + exp_rd_q.size()), 64'd0);
    repeat (3) step(1'b1, 1'b1);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [NS-1:0] rd;
    logic          valid;
    logic          bsy;
    logic [SW-1:0] src;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tv [7];

  initial begin
    logic [63:0] got;
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    n_tests = 0; n_fail = 0; mon_on = 1'b0;
    for (int i = 0; i < NS; i++) begin lim[i] = 0; next_idx[i] = 0; end
    clear_mon();

    // Source 1 with 3 words, consumer always ready: cycle-exact view.
    tv[0] = '{4'b0010, 1'b0, 1'b0, 2'd0, 32'd0};
    tv[1] = '{4'b0010, 1'b0, 1'b1, 2'd0, 32'd0};
    tv[2] = '{4'b0010, 1'b1, 1'b1, 2'd1, word(1, 0)};
    tv[3] = '{4'b0000, 1'b1, 1'b1, 2'd1, word(1, 1)};
    tv[4] = '{4'b0000, 1'b1, 1'b1, 2'd1, word(1, 2)};
    tv[5] = '{4'b0000, 1'b0, 1'b0, 2'd0, 32'd0};
    tv[6] = '{4'b0000, 1'b0, 1'b0, 2'd0, 32'd0};

    repeat (2) @(negedge clk);
    enable = 1'b1; out_ready = 1'b1;
    load(1, 3);
    check_zero("reset_outputs");
    release_reset();
    for (int v = 0; v < 7; v++) begin
      step(1'b1, 1'b1);
      got = {24'd0, src_read_en, out_valid, busy,
             (out_valid ? out_src : 2'd0), (out_valid ? out_data : 32'd0)};
      check($sformatf("table_cycle_%0d", v), got,
            {24'd0, tv[v].rd, tv[v].valid, tv[v].bsy, tv[v].src, tv[v].data});
    end
    next_idx[1] = 3;

    // All sources full: 8-read bursts rotating 0..3, then the 4-word tails.
    start_scenario();
    for (int s = 0; s < NS; s++) load(s, 20);
    for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) expect_burst(s, 8);
    for (int s = 0; s < NS; s++) expect_burst(s, 4);
    check_zero("s2_reset_outputs");
    release_reset();
    run_until_empty("s2", 300);
    check("s2_gaps", 64'(gaps), 64'd11);
    check("s2_delivered", 64'(delivered), 64'd80);

    // Back-pressure pattern 1,0,0,1 on a 5-word source.
    start_scenario();
    load(2, 5);
    expect_burst(2, 5);
    release_reset();
    for (int c = 0; c < 100 && (exp_q.size() != 0 || exp_rd_q.size() != 0); c++)
      step(1'b1, ((c % 4) == 0) || ((c % 4) == 3));
    check("s3_drained", 64'(exp_q.size() + exp_rd_q.size()), 64'd0);
    check("s3_delivered", 64'(delivered), 64'd5);

    // Wrap-around: 0 bursts, then 3, then back to 0.
    start_scenario();
    load(0, 10);
    load(3, 2);
    expect_burst(0, 8);
    expect_burst(3, 2);
    expect_burst(0, 2);
    release_reset();
    run_until_empty("s4", 100);
    check("s4_gaps", 64'(gaps), 64'd2);

    // enable falls after the second strobe: in-flight read still delivers.
    start_scenario();
    load(1, 6);
    expect_burst(1, 6);
    release_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    check("s5_words_disabled", 64'(delivered), 64'd2);
    check("s5_strobes_disabled", 64'(strobes), 64'd2);
    check("s5_busy_disabled", 64'(busy), 64'd0);
    run_until_empty("s5", 60);
    check("s5_delivered", 64'(delivered), 64'd6);

    // Asynchronous reset with two words buffered and consumer stalled.
    start_scenario();
    load(2, 6);
    expect_burst(2, 2);
    release_reset();
    repeat (4) step(1'b1, 1'b0);
    check("s6_buffered", {62'd0, out_valid, busy}, 64'd3);
    check("s6_outstanding", 64'(outstanding), 64'd2);
    check("s6_reads_done", 64'(exp_rd_q.size()), 64'd0);
    #1 rst = 1'b1;
    check_zero("s6_async_reset");
    clear_mon();
    load(1, 3);
    expect_burst(1, 3);
    expect_burst(2, 4);
    release_reset();
    run_until_empty("s6", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
